// File: rtl/osc_bank_if.sv
// Host config port and mixed sample output of the oscillator bank.
interface osc_bank_if #(
  parameter int CH_BITS   = 2,
  parameter int WAVE_BITS = 6
);
  logic                         cfg_valid;
  logic                         cfg_ready;
  logic [CH_BITS:0]             cfg_addr;
  logic [15:0]                  cfg_wdata;
  logic [WAVE_BITS+CH_BITS-1:0] mix_out;
  logic                         sample_valid;

  modport master (output cfg_valid, cfg_addr, cfg_wdata,
                  input  cfg_ready, mix_out, sample_valid);
  modport slave  (input  cfg_valid, cfg_addr, cfg_wdata,
                  output cfg_ready, mix_out, sample_valid);
endinterface

// File: rtl/osc_bank.sv
// Time-multiplexed oscillator bank: one channel serviced per slot, one summed
// sample per frame of NUM_CH+1 cycles, with per-channel saturating pitch sweep.
module osc_bank #(
  parameter int NUM_CH      = 4,
  parameter int CH_BITS     = 2,
  parameter int OCT_BITS    = 4,
  parameter int MANT_BITS   = 10,
  parameter int WAVE_BITS   = 6,
  parameter int DIV_BITS    = 18,
  parameter int SWEEP_SHIFT = 2
) (
  input  logic       clk,
  input  logic       reset,
  osc_bank_if.slave  bus
);
  localparam int PF_BITS   = MANT_BITS - 1 + OCT_BITS;
  localparam int SLOT_BITS = $clog2(NUM_CH + 1);
  localparam int NTICK     = 2**OCT_BITS + SWEEP_SHIFT;
  localparam int TI_BITS   = $clog2(NTICK);
  localparam int MIX_BITS  = WAVE_BITS + CH_BITS;

  logic [NUM_CH-1:0][15:0]          word0, word1;
  logic [NUM_CH-1:0][WAVE_BITS-1:0] phase;
  logic [NUM_CH-1:0][MANT_BITS-1:0] cnt;
  logic [SLOT_BITS-1:0]             slot;
  logic [DIV_BITS-1:0]              div, div_inc, div_rise;
  logic [MIX_BITS-1:0]              acc, mix_q;
  logic                             sv_q;

  // tick[k] marks the frame whose end-of-frame increment raises divider bit k-1
  logic [NTICK-1:0] tick;
  assign div_inc  = div + 1'b1;
  assign div_rise = div_inc & ~div;
  assign tick[0]  = 1'b1;
  for (genvar k = 1; k < NTICK; k++) begin : g_tick
    if (k <= DIV_BITS) begin : g_bit
      assign tick[k] = div_rise[k-1];
    end else begin : g_none
      assign tick[k] = 1'b0;
    end
  end

  logic                 in_ch;
  logic [CH_BITS-1:0]   ch;
  logic [PF_BITS-1:0]   pf, pf_step;
  logic [MANT_BITS-2:0] mant;
  logic [OCT_BITS-1:0]  oct, sw_oct;
  logic [TI_BITS-1:0]   sw_idx;
  logic [1:0]           mode;
  logic [3:0]           duty;
  logic                 sw_down, sw_on;

  assign in_ch   = slot < SLOT_BITS'(NUM_CH);
  assign ch      = slot[CH_BITS-1:0];
  assign pf      = word0[ch][PF_BITS-1:0];
  assign mant    = pf[MANT_BITS-2:0];
  assign oct     = pf[PF_BITS-1 -: OCT_BITS];
  assign mode    = word1[ch][1:0];
  assign duty    = word1[ch][5:2];
  assign sw_down = word1[ch][6];
  assign sw_on   = word1[ch][7];
  assign sw_oct  = word1[ch][8 +: OCT_BITS];
  assign sw_idx  = TI_BITS'(sw_oct) + TI_BITS'(SWEEP_SHIFT);
  assign pf_step = sw_down ? pf - 1'b1 : pf + 1'b1;

  logic osc_en, sweep_we;
  assign osc_en   = in_ch && (mode != 2'b00) && (oct != '1) && tick[oct];
  assign sweep_we = in_ch && sw_on && (sw_oct != '1) && tick[sw_idx] &&
                    (sw_down ? (pf != '0) : (pf != '1));

  logic [WAVE_BITS-1:0] wave;
  always_comb begin
    wave = '0;
    case (mode)
      2'b01:   wave = phase[ch];
      2'b10:   wave = {WAVE_BITS{phase[ch][WAVE_BITS-1]}};
      2'b11:   wave = (phase[ch][WAVE_BITS-1 -: 4] < duty) ? '1 : '0;
      default: wave = '0;
    endcase
  end

  // Sweep has priority on the config port; the host retries while ready is low
  logic               host_we;
  logic [CH_BITS-1:0] host_ch;
  assign bus.cfg_ready = !sweep_we;
  assign host_ch       = bus.cfg_addr[CH_BITS:1];
  assign host_we       = bus.cfg_valid && !sweep_we &&
                         ({1'b0, host_ch} < (CH_BITS+1)'(NUM_CH));

  always_ff @(posedge clk) begin
    if (reset) begin
      word0 <= '1;
      word1 <= '0;
      phase <= '0;
      cnt   <= '0;
      slot  <= '0;
      div   <= '0;
      acc   <= '0;
      mix_q <= '0;
      sv_q  <= 1'b0;
    end else begin
      sv_q <= !in_ch;
      if (in_ch) begin
        acc  <= acc + MIX_BITS'(wave);
        slot <= slot + 1'b1;
        if (osc_en) begin
          if (cnt[ch] == '0) begin
            cnt[ch]   <= {1'b1, mant} - 1'b1;
            phase[ch] <= phase[ch] + 1'b1;
          end else begin
            cnt[ch] <= cnt[ch] - 1'b1;
          end
        end
      end else begin
        mix_q <= acc;
        acc   <= '0;
        div   <= div_inc;
        slot  <= '0;
      end
      if (sweep_we) begin
        word0[ch][PF_BITS-1:0] <= pf_step;
      end else if (host_we) begin
        if (bus.cfg_addr[0]) word1[host_ch] <= bus.cfg_wdata;
        else                 word0[host_ch] <= bus.cfg_wdata;
      end
    end
  end

  assign bus.mix_out      = mix_q;
  assign bus.sample_valid = sv_q;

  // Stored-but-unused config bits and the divider top rise bit
  logic unused_bits;
  assign unused_bits = ^{word0, word1, div_rise};
endmodule

// File: tb/tb_osc_bank.sv
// Bench for osc_bank: frame-level reference model checked every cycle, plus
// a vector table and directed sequences for rate, sweep, stall and reset.
module tb_osc_bank;
  localparam int NC = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  osc_bank_if #(.CH_BITS(2), .WAVE_BITS(6)) bus ();
  osc_bank #(.NUM_CH(4), .CH_BITS(2), .OCT_BITS(4), .MANT_BITS(10),
             .WAVE_BITS(6), .DIV_BITS(18), .SWEEP_SHIFT(2))
    dut (.clk(clk), .reset(reset), .bus(bus));

  int n_pass = 0;
  int n_tot  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference model: per-channel words, phase, countdown; frame index as divider
  int m_w0[NC], m_w1[NC], m_ph[NC], m_cnt[NC];
  int m_slot, m_frame, m_acc, m_mix, m_sv;

  function automatic bit m_tick(input int k);
    if (k == 0) return 1'b1;
    return ((m_frame + 1) % (1 << k)) == (1 << (k - 1));
  endfunction

  function automatic bit m_sweep();
    int c, pf, so;
    if (m_slot >= NC) return 1'b0;
    c  = m_slot;
    pf = m_w0[c] & 'h1FFF;
    so = (m_w1[c] >> 8) & 15;
    if (((m_w1[c] >> 7) & 1) == 0 || so == 15 || !m_tick(so + 2)) return 1'b0;
    if (((m_w1[c] >> 6) & 1) == 1) return pf != 0;
    return pf != 'h1FFF;
  endfunction

  task automatic m_step();
    int c, pf, oct, mode, duty, wave, a;
    bit swe;
    if (reset) begin
      for (int i = 0; i < NC; i++) begin
        m_w0[i] = 'hFFFF; m_w1[i] = 0; m_ph[i] = 0; m_cnt[i] = 0;
      end
      m_slot = 0; m_frame = 0; m_acc = 0; m_mix = 0; m_sv = 0;
      return;
    end
    swe  = m_sweep();
    m_sv = (m_slot == NC);
    if (m_slot == NC) begin
      m_mix = m_acc; m_acc = 0;
      m_frame = (m_frame + 1) % (1 << 18);
    end else begin
      c    = m_slot;
      pf   = m_w0[c] & 'h1FFF;
      oct  = pf >> 9;
      mode = m_w1[c] & 3;
      duty = (m_w1[c] >> 2) & 15;
      case (mode)
        1: wave = m_ph[c];
        2: wave = (m_ph[c] >= 32) ? 63 : 0;
        3: wave = ((m_ph[c] >> 2) < duty) ? 63 : 0;
        default: wave = 0;
      endcase
      m_acc += wave;
      if (mode != 0 && oct != 15 && m_tick(oct)) begin
        if (m_cnt[c] == 0) begin
          m_cnt[c] = 512 + (pf & 511) - 1;
          m_ph[c]  = (m_ph[c] + 1) % 64;
        end else m_cnt[c]--;
      end
      if (swe) m_w0[c] = (m_w0[c] & 'hE000) |
                         ((((m_w1[c] >> 6) & 1) == 1) ? pf - 1 : pf + 1);
    end
    if (!swe && bus.cfg_valid) begin
      a = int'(bus.cfg_addr);
      if (a & 1) m_w1[a >> 1] = int'(bus.cfg_wdata);
      else       m_w0[a >> 1] = int'(bus.cfg_wdata);
    end
    m_slot = (m_slot + 1) % (NC + 1);
  endtask

  // One clock: compare outputs mid-cycle, advance model, land just past the edge
  task automatic cycle();
    @(negedge clk);
    check("cfg_ready", int'(bus.cfg_ready), int'(!m_sweep()));
    check("sample_valid", int'(bus.sample_valid), m_sv);
    check("mix_out", int'(bus.mix_out), m_mix);
    m_step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) cycle();
    reset = 1'b0;
  endtask

  task automatic host_wr(input int addr, input int data);
    bus.cfg_valid = 1'b1;
    bus.cfg_addr  = 3'(addr);
    bus.cfg_wdata = 16'(data);
    cycle();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic next_sample(output int v);
    v = -1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (bus.sample_valid) begin
        v = int'(bus.mix_out);
        return;
      end
    end
  endtask

  task automatic wait_change(output int n, output int v);
    int v0;
    next_sample(v0);
    for (int i = 1; i <= 1200; i++) begin
      next_sample(v);
      if (v != v0) begin n = i; return; end
    end
    n = -1;
  endtask

  task automatic count_ready_low(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      if (!bus.cfg_ready) n++;
      cycle();
    end
  endtask

  task automatic first_pulse(output int n, output int v);
    n = 0; v = -1;
    while (!bus.sample_valid && n < 12) begin cycle(); n++; end
    if (bus.sample_valid) v = int'(bus.mix_out);
  endtask

  typedef struct {
    logic [63:0] w0;   // {ch3, ch2, ch1, ch0} word0
    logic [63:0] w1;   // {ch3, ch2, ch1, ch0} word1
    int          exp_mix;
  } vec_t;
  vec_t vecs[8];

  initial begin
    int n, v, w;
    vecs[0] = '{64'h0, 64'h0001_0001_0001_0001, 4};
    vecs[1] = '{64'h0, 64'h0002_0002_0002_0002, 0};
    vecs[2] = '{64'h0, 64'h0023_0023_0023_0023, 252};
    vecs[3] = '{64'h0, 64'h0003_0003_0003_0003, 0};
    vecs[4] = '{64'h0, 64'h0000_0002_0007_0001, 64};
    vecs[5] = '{64'h0000_1E00_0000_1E00, 64'h0000_0007_0001_0001, 64};
    vecs[6] = '{64'h0200_0200_0200_0200, 64'h0001_0001_0001_0001, 4};
    vecs[7] = '{64'h0000_0000_0000_1C00, 64'h0001_003F_0001_0001, 65};

    reset = 1'b1;
    bus.cfg_valid = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
    m_step();
    @(posedge clk); #1;

    // Reset state and idle frame cadence
    do_reset(3);
    check("rst_ready", int'(bus.cfg_ready), 1);
    first_pulse(n, v);
    check("rst_first_pulse", n, 5);
    check("rst_first_mix", v, 0);
    cycle();
    count_ready_low(20, n);
    check("rst_ready_steady", n, 0);

    // Static waveform/mix table, a few frames after configuration
    for (int i = 0; i < 8; i++) begin
      do_reset(1);
      for (int c = 0; c < NC; c++) begin
        host_wr(2 * c,     int'(vecs[i].w0[16 * c +: 16]));
        host_wr(2 * c + 1, int'(vecs[i].w1[16 * c +: 16]));
      end
      repeat (20) cycle();
      next_sample(v);
      check($sformatf("vec%0d_mix", i), v, vecs[i].exp_mix);
    end

    // Saw step interval at oct 0 then oct 1
    do_reset(1);
    host_wr(0, 'h0000);
    host_wr(1, 'h0001);
    wait_change(n, v);
    wait_change(n, v);
    check("saw_step_frames", n + 1, 512);
    check("saw_step_val", v, 2);
    host_wr(0, 'h0200);
    wait_change(n, v);
    wait_change(n, v);
    check("oct1_step_frames", n + 1, 1024);
    check("oct1_step_val", v, 4);

    // Sweep saturation up and down, frozen sweep octave
    do_reset(1);
    host_wr(2, 'h1FFE);
    host_wr(3, 'h0080);
    count_ready_low(50, n);
    check("sweep_up_sat", n, 1);
    do_reset(1);
    host_wr(2, 'h0000);
    host_wr(3, 'h00C0);
    count_ready_low(50, n);
    check("sweep_down_zero", n, 0);
    host_wr(2, 'h0001);
    count_ready_low(50, n);
    check("sweep_down_sat", n, 1);
    host_wr(3, 'h0F80);
    host_wr(2, 'h0100);
    count_ready_low(50, n);
    check("sweep_oct_frozen", n, 0);

    // Host write held across the sweep cycle
    do_reset(1);
    host_wr(2, 'h1FFE);
    host_wr(3, 'h0080);
    n = 0;
    while (!m_sweep() && n < 40) begin cycle(); n++; end
    bus.cfg_valid = 1'b1; bus.cfg_addr = 3'd2; bus.cfg_wdata = 16'h0123;
    check("stall_ready", int'(bus.cfg_ready), 0);
    cycle();
    check("stall_accept", int'(bus.cfg_ready), 1);
    cycle();
    bus.cfg_valid = 1'b0;
    count_ready_low(30, n);
    check("stall_resweep", int'(n > 0), 1);

    // Reset mid-frame with channels running
    do_reset(1);
    for (int c = 0; c < NC; c++) begin
      host_wr(2 * c, 'h0000);
      host_wr(2 * c + 1, 'h0023);
    end
    repeat (12) cycle();
    n = 0;
    while (m_slot != 2 && n < 6) begin cycle(); n++; end
    check("midrst_slot", m_slot, 2);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("midrst_ready", int'(bus.cfg_ready), 1);
    check("midrst_mix", int'(bus.mix_out), 0);
    first_pulse(n, v);
    check("midrst_pulse", n, 5);
    check("midrst_pulse_mix", v, 0);

    // Randomized host traffic against the model
    do_reset(1);
    for (int i = 0; i < 15000; i++) begin
      n = $urandom_range(0, 7);
      if (n % 2 == 0) begin
        v = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2);
        w = ($urandom_range(0, 7) << 13) | (v << 9) | $urandom_range(0, 511);
      end else begin
        v = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 1);
        w = ($urandom_range(0, 15) << 12) | (v << 8) | $urandom_range(0, 255);
      end
      bus.cfg_valid = ($urandom_range(0, 2) == 0);
      bus.cfg_addr  = 3'(n);
      bus.cfg_wdata = 16'(w);
      cycle();
    end
    bus.cfg_valid = 1'b0;
    repeat (10) cycle();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
